// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB first,
// optional parity, one or two stop bits.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_busy,
  output logic       tx,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    byte_q, byte_d;
  logic          stop_q, stop_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bit_end;
  logic          par;

  assign bit_end = (cnt_q == CNT_MAX);
  // Parity comes from the latched byte; the shifter is consumed by then.
  assign par     = (^byte_q) ^ PAR_ODD;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    byte_d  = byte_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_data_valid) begin
          sh_d    = tx_data;
          byte_d  = tx_data;
          tx_d    = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          stop_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = sh_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          sh_d  = sh_q >> 1;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            if (PAR_EN) begin
              tx_d    = par;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            tx_d = sh_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    // Registered pulse lands on the final cycle of the last stop bit.
    done_d = (state_d == S_STOP) && (cnt_d == CNT_MAX)
             && (stop_d == STOP_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      byte_q  <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      byte_q  <= byte_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Combinational so the bridge sees busy in the strobe cycle itself.
  assign tx_busy = (state_q != S_IDLE) | tx_data_valid;
  assign tx      = tx_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four parameter sets
// at CLKS_PER_BIT=4, checked cycle by cycle.
module tb_uart_tx_serializer;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic [3:0] vld;
  logic [3:0] busy_w;
  logic [3:0] tx_w;
  logic [3:0] done_w;

  int passed;
  int total;

  uart_tx_serializer #(
    .CLKS_PER_BIT(N), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .reset(reset), .tx_data(tx_data),
    .tx_data_valid(vld[0]), .tx_busy(busy_w[0]),
    .tx(tx_w[0]), .tx_done(done_w[0])
  );

  uart_tx_serializer #(
    .CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_b (
    .clk(clk), .reset(reset), .tx_data(tx_data),
    .tx_data_valid(vld[1]), .tx_busy(busy_w[1]),
    .tx(tx_w[1]), .tx_done(done_w[1])
  );

  uart_tx_serializer #(
    .CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
  ) dut_c (
    .clk(clk), .reset(reset), .tx_data(tx_data),
    .tx_data_valid(vld[2]), .tx_busy(busy_w[2]),
    .tx(tx_w[2]), .tx_done(done_w[2])
  );

  uart_tx_serializer #(
    .CLKS_PER_BIT(N), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)
  ) dut_d (
    .clk(clk), .reset(reset), .tx_data(tx_data),
    .tx_data_valid(vld[3]), .tx_busy(busy_w[3]),
    .tx(tx_w[3]), .tx_done(done_w[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int j,
                                   input int pe, input int odd);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == 9 && pe != 0) return (^b) ^ (odd != 0);
    return 1'b1;
  endfunction

  // Sends one byte on DUT sel and checks every cycle of the frame.
  // noise: stray strobe + data change mid-frame; post: check idle after;
  // abort: cycle at which reset is pulsed (0 = never).
  task automatic frame(input int sel, input logic [7:0] b, input int pe,
                       input int odd, input int sb, input bit noise,
                       input bit post, input int abort);
    int len;
    len = (10 + pe + sb - 1) * N;
    @(negedge clk);
    vld[sel] = 1'b1;
    tx_data  = b;
    #1;
    chk($sformatf("d%0d_%0h_strobe_busy", sel, b), 8'(busy_w[sel]), 8'h1);
    @(posedge clk);
    #1;
    vld[sel] = 1'b0;
    tx_data  = 8'h00;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == abort) begin
        reset = 1'b0;
        #1;
        chk($sformatf("d%0d_abort_tx", sel), 8'(tx_w[sel]), 8'h1);
        chk($sformatf("d%0d_abort_busy", sel), 8'(busy_w[sel]), 8'h0);
        for (int r = 0; r < 3; r++) begin
          @(negedge clk);
          chk($sformatf("d%0d_abort_done%0d", sel, r),
              8'(done_w[sel]), 8'h0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk($sformatf("d%0d_post_rst_tx", sel), 8'(tx_w[sel]), 8'h1);
        chk($sformatf("d%0d_post_rst_done", sel), 8'(done_w[sel]), 8'h0);
        return;
      end
      chk($sformatf("d%0d_%0h_tx_c%0d", sel, b, k), 8'(tx_w[sel]),
          8'(exp_bit(b, (k - 1) / N, pe, odd)));
      chk($sformatf("d%0d_%0h_busy_c%0d", sel, b, k), 8'(busy_w[sel]),
          8'h1);
      chk($sformatf("d%0d_%0h_done_c%0d", sel, b, k), 8'(done_w[sel]),
          8'(k == len));
      if (noise && k == 10) begin
        vld[sel] = 1'b1;
        tx_data  = ~b;
      end else begin
        vld[sel] = 1'b0;
      end
    end
    if (post) begin
      @(negedge clk);
      chk($sformatf("d%0d_%0h_idle_busy", sel, b), 8'(busy_w[sel]), 8'h0);
      chk($sformatf("d%0d_%0h_idle_tx", sel, b), 8'(tx_w[sel]), 8'h1);
      chk($sformatf("d%0d_%0h_idle_done", sel, b), 8'(done_w[sel]), 8'h0);
    end
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    reset   = 1'b0;
    vld     = 4'h0;
    tx_data = 8'h00;
    #12;
    chk("rst_tx", {4'h0, tx_w}, 8'h0f);
    chk("rst_busy", {4'h0, busy_w}, 8'h00);
    chk("rst_done", {4'h0, done_w}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_tx", {4'h0, tx_w}, 8'h0f);

    frame(0, 8'hA5, 0, 0, 1, 1'b0, 1'b1, 0);
    frame(1, 8'h07, 1, 0, 1, 1'b0, 1'b1, 0);
    frame(2, 8'h07, 1, 1, 1, 1'b0, 1'b1, 0);
    frame(3, 8'h00, 0, 0, 2, 1'b0, 1'b1, 0);
    frame(2, 8'hC3, 1, 1, 1, 1'b1, 1'b1, 0);

    frame(0, 8'h55, 0, 0, 1, 1'b1, 1'b0, 0);
    frame(0, 8'hAA, 0, 0, 1, 1'b1, 1'b1, 0);

    frame(0, 8'hFF, 0, 0, 1, 1'b0, 1'b0, 15);
    frame(0, 8'h3C, 0, 0, 1, 1'b0, 1'b1, 0);

    frame(0, 8'h12, 0, 0, 1, 1'b0, 1'b0, 0);
    frame(0, 8'h34, 0, 0, 1, 1'b0, 1'b0, 0);
    frame(0, 8'h56, 0, 0, 1, 1'b0, 1'b1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
